// File: rtl/ptp_regs_seq.sv
// ptp_regs_seq: bus-master sequencer for the PTP register file.
// Expands one command into the control-bit edge, settle wait, ok-flag polling
// and result burst, then presents a single packed response.
module ptp_regs_seq #(
  parameter int SETTLE_CYC = 4,
  parameter int POLL_MAX   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_op,
  output logic         rsp_err,
  output logic [7:0]   rsp_stat,
  output logic [127:0] rsp_data,
  output logic         wr_out,
  output logic         rd_out,
  output logic [7:0]   addr_out,
  output logic [31:0]  data_out,
  input  logic [31:0]  data_in
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLR      = 3'd1;
  localparam logic [2:0] ST_SET      = 3'd2;
  localparam logic [2:0] ST_SETTLE   = 3'd3;
  localparam logic [2:0] ST_POLL_RD  = 3'd4;
  localparam logic [2:0] ST_POLL_CHK = 3'd5;
  localparam logic [2:0] ST_FETCH    = 3'd6;
  localparam logic [2:0] ST_RESP     = 3'd7;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] POLL_LIMIT  = 8'(POLL_MAX);

  logic [2:0]   state_reg;
  logic [1:0]   op_reg;
  logic [3:0]   settle_cnt_reg;
  logic [7:0]   poll_cnt_reg;
  logic [2:0]   fetch_cnt_reg;
  logic [15:0]  word0_reg;
  logic [1:0]   rsp_op_reg;
  logic         rsp_err_reg;
  logic [7:0]   rsp_stat_reg;
  logic [127:0] rsp_data_reg;

  logic [7:0]   ctrl_addr;
  logic [7:0]   fetch_addr;
  logic [2:0]   fetch_len;
  logic         fetch_issue;
  logic         fetch_last;
  logic [15:0]  cap_word0;
  logic [31:0]  cap_word [1:4];
  logic [7:0]   pack_stat;
  logic [127:0] pack_data;

  // Control register and burst addresses for the command in flight
  always_comb begin
    ctrl_addr  = 8'h00;
    fetch_addr = 8'h10 + {3'b000, fetch_cnt_reg, 2'b00};
    fetch_len  = 3'd5;
    case (op_reg)
      2'd1: begin
        ctrl_addr  = 8'h40;
        fetch_addr = (fetch_cnt_reg == 3'd0) ? 8'h44 : 8'h4C + {3'b000, fetch_cnt_reg, 2'b00};
      end
      2'd2: begin
        ctrl_addr  = 8'h60;
        fetch_addr = (fetch_cnt_reg == 3'd0) ? 8'h64 : 8'h6C + {3'b000, fetch_cnt_reg, 2'b00};
      end
      default: fetch_len = 3'd4;
    endcase
  end

  assign fetch_issue = (fetch_cnt_reg < fetch_len);
  assign fetch_last  = (fetch_cnt_reg == fetch_len);

  // The word whose read was issued last cycle is taken straight from data_in so
  // packing can happen in the same cycle the final word arrives.
  assign cap_word0 = (fetch_cnt_reg == 3'd1) ? data_in[15:0] : word0_reg;

  genvar gi;
  generate
    for (gi = 1; gi < 5; gi++) begin : g_word
      logic [31:0] word_reg;
      // Capture burst word gi the cycle after its read
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (state_reg == ST_FETCH && fetch_cnt_reg == 3'(gi + 1)) begin
          word_reg <= data_in;
        end
      end
      assign cap_word[gi] = (fetch_cnt_reg == 3'(gi + 1)) ? data_in : word_reg;
    end
  endgenerate

  // Response packing: time fields for op 0, status + four queue words otherwise
  always_comb begin
    pack_stat = 8'h00;
    pack_data = '0;
    if (op_reg == 2'd0) begin
      pack_data = {42'd0, cap_word0, cap_word[1], cap_word[2][29:0], cap_word[3][7:0]};
    end else begin
      pack_stat = cap_word0[7:0];
      pack_data = {cap_word[1], cap_word[2], cap_word[3], cap_word[4]};
    end
  end

  // Command sequencing state machine and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      op_reg         <= 2'd0;
      settle_cnt_reg <= 4'd0;
      poll_cnt_reg   <= 8'd0;
      fetch_cnt_reg  <= 3'd0;
      word0_reg      <= 16'h0000;
      rsp_op_reg     <= 2'd0;
      rsp_err_reg    <= 1'b0;
      rsp_stat_reg   <= 8'h00;
      rsp_data_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg         <= cmd_op;
            rsp_op_reg     <= cmd_op;
            settle_cnt_reg <= 4'd0;
            poll_cnt_reg   <= 8'd0;
            fetch_cnt_reg  <= 3'd0;
            if (cmd_op == 2'd3) begin
              rsp_err_reg  <= 1'b1;
              rsp_stat_reg <= 8'h00;
              rsp_data_reg <= '0;
              state_reg    <= ST_RESP;
            end else begin
              state_reg <= ST_CLR;
            end
          end
        end
        ST_CLR: state_reg <= ST_SET;
        ST_SET: state_reg <= ST_SETTLE;
        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= ST_POLL_RD;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
          end
        end
        ST_POLL_RD: begin
          poll_cnt_reg <= poll_cnt_reg + 8'd1;
          state_reg    <= ST_POLL_CHK;
        end
        ST_POLL_CHK: begin
          if (data_in[0]) begin
            state_reg <= ST_FETCH;
          end else if (poll_cnt_reg < POLL_LIMIT) begin
            state_reg <= ST_POLL_RD;
          end else begin
            rsp_err_reg  <= 1'b1;
            rsp_stat_reg <= 8'h00;
            rsp_data_reg <= '0;
            state_reg    <= ST_RESP;
          end
        end
        ST_FETCH: begin
          if (fetch_cnt_reg == 3'd1) begin
            word0_reg <= data_in[15:0];
          end
          if (fetch_last) begin
            rsp_err_reg  <= 1'b0;
            rsp_stat_reg <= pack_stat;
            rsp_data_reg <= pack_data;
            state_reg    <= ST_RESP;
          end else begin
            fetch_cnt_reg <= fetch_cnt_reg + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bus strobes decoded from state; address/data forced to 0 when idle
  always_comb begin
    wr_out   = 1'b0;
    rd_out   = 1'b0;
    addr_out = 8'h00;
    data_out = 32'h0;
    case (state_reg)
      ST_CLR: begin
        wr_out   = 1'b1;
        addr_out = ctrl_addr;
      end
      ST_SET: begin
        wr_out   = 1'b1;
        addr_out = ctrl_addr;
        data_out = 32'h1;
      end
      ST_POLL_RD: begin
        rd_out   = 1'b1;
        addr_out = ctrl_addr;
      end
      ST_FETCH: begin
        if (fetch_issue) begin
          rd_out   = 1'b1;
          addr_out = fetch_addr;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_op    = rsp_op_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_stat  = rsp_stat_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_ptp_regs_seq.sv
// tb_ptp_regs_seq: directed bench for ptp_regs_seq with a register-file slave
// model and a per-cycle bus checker driven by a command-level timing model.
module tb_ptp_regs_seq;

  localparam int S  = 4;
  localparam int PM = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_op;
  logic         rsp_err;
  logic [7:0]   rsp_stat;
  logic [127:0] rsp_data;
  logic         wr_out;
  logic         rd_out;
  logic [7:0]   addr_out;
  logic [31:0]  data_out;
  logic [31:0]  data_in;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ptp_regs_seq #(.SETTLE_CYC(S), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
    .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out),
    .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file slave: 1-cycle registered read, ok flag after ok_poll polls
  logic [31:0] regs [int];
  logic [7:0]  cur_ca;
  int          ok_poll;
  int          poll_seen;

  function automatic logic [31:0] rv(input int a);
    return regs.exists(a) ? regs[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rd_out) begin
      if (addr_out == cur_ca) begin
        poll_seen = poll_seen + 1;
        data_in <= (ok_poll != 0 && poll_seen >= ok_poll) ? 32'h1 : 32'hFFFF_FFFE;
      end else begin
        data_in <= rv(int'(addr_out));
      end
    end else begin
      data_in <= 32'hDEAD_BEEF;
    end
  end

  // Expected bus activity per absolute cycle (kind 1 = write, 2 = read)
  int           exp_kind [int];
  logic [7:0]   exp_a [int];
  logic [31:0]  exp_d [int];
  int           exp_rsp_cyc;
  logic [1:0]   exp_op;
  logic         exp_err;
  logic [7:0]   exp_stat;
  logic [127:0] exp_data;
  bit           chk_en = 1'b0;
  int           got_rsp_cyc;
  logic [127:0] got_data;
  logic [7:0]   got_stat;
  int           last_t0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Command-level timing model: fills bus expectations and the response
  task automatic model_expect(input logic [1:0] op, input int t0);
    int fa [5];
    int n;
    int npoll;
    int p;
    logic [31:0] w [5];
    logic [7:0] ca;
    logic [63:0] secs;
    logic [63:0] ns;
    poll_seen = 0;
    exp_op   = op;
    exp_err  = 1'b1;
    exp_stat = 8'h00;
    exp_data = '0;
    if (op == 2'd3) begin
      exp_rsp_cyc = t0 + 1;
      return;
    end
    ca = (op == 2'd0) ? 8'h00 : (op == 2'd1) ? 8'h40 : 8'h60;
    cur_ca = ca;
    exp_kind[t0+1] = 1; exp_a[t0+1] = ca; exp_d[t0+1] = 32'h0;
    exp_kind[t0+2] = 1; exp_a[t0+2] = ca; exp_d[t0+2] = 32'h1;
    npoll = (ok_poll == 0) ? PM : ok_poll;
    p = 0;
    for (int i = 0; i < npoll; i++) begin
      p = t0 + 3 + S + 2 * i;
      exp_kind[p] = 2; exp_a[p] = ca;
    end
    if (ok_poll == 0) begin
      exp_rsp_cyc = p + 2;
      return;
    end
    case (op)
      2'd0: begin fa = '{'h10, 'h14, 'h18, 'h1C, 0}; n = 4; end
      2'd1: begin fa = '{'h44, 'h50, 'h54, 'h58, 'h5C}; n = 5; end
      default: begin fa = '{'h64, 'h70, 'h74, 'h78, 'h7C}; n = 5; end
    endcase
    for (int j = 0; j < 5; j++) w[j] = 32'h0;
    for (int j = 0; j < n; j++) begin
      exp_kind[p+2+j] = 2; exp_a[p+2+j] = 8'(fa[j]);
      w[j] = rv(fa[j]);
    end
    exp_rsp_cyc = p + 2 + n + 1;
    exp_err = 1'b0;
    if (op == 2'd0) begin
      secs = 64'(w[0] & 32'h0000_FFFF) * 64'h1_0000_0000 + 64'(w[1]);
      ns   = 64'(w[2] & 32'h3FFF_FFFF) * 64'd256 + 64'(w[3] & 32'hFF);
      exp_data = (128'(secs) << 38) + 128'(ns);
    end else begin
      exp_stat = w[0][7:0];
      for (int j = 1; j < 5; j++) exp_data = (exp_data << 32) | 128'(w[j]);
    end
  endtask

  // Per-cycle bus checker against the model's expectations
  int          ck_k;
  logic [7:0]  ck_a;
  logic [31:0] ck_d;
  always @(negedge clk) begin
    if (chk_en) begin
      ck_k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
      ck_a = (ck_k != 0) ? exp_a[cyc] : 8'h00;
      ck_d = (ck_k == 1) ? exp_d[cyc] : 32'h0;
      tests++;
      if (wr_out !== (ck_k == 1) || rd_out !== (ck_k == 2) || addr_out !== ck_a || data_out !== ck_d) begin
        fails++;
        $display("FAIL bus cyc=%0d got wr=%b rd=%b addr=%h data=%h want wr=%b rd=%b addr=%h data=%h",
                 cyc, wr_out, rd_out, addr_out, data_out, ck_k == 1, ck_k == 2, ck_a, ck_d);
      end
    end
  end

  // Present a command at a negedge and hold it until accepted
  task automatic issue(input logic [1:0] op);
    int g = 0;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_accept", 128'(cmd_ready), 128'd1);
    last_t0 = cyc;
    model_expect(op, cyc);
    $display("[TB] cmd op=%0d accepted at cycle %0d", op, cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
  endtask

  // Wait for the response, check it, optionally stall, then accept it
  task automatic wait_rsp(input int hold, input bit ack, input string nm);
    int g = 0;
    while (!rsp_valid && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_valid"}, 128'(rsp_valid), 128'd1);
    if (!rsp_valid) return;
    got_rsp_cyc = cyc;
    got_data = rsp_data;
    got_stat = rsp_stat;
    chk({nm, "_cycle"}, 128'(cyc), 128'(exp_rsp_cyc));
    chk({nm, "_op"}, 128'(rsp_op), 128'(exp_op));
    chk({nm, "_err"}, 128'(rsp_err), 128'(exp_err));
    chk({nm, "_stat"}, 128'(rsp_stat), 128'(exp_stat));
    chk({nm, "_data"}, rsp_data, exp_data);
    $display("[TB] rsp %s at cycle %0d (+%0d) op=%0d err=%b stat=%h data=%h",
             nm, cyc, cyc - last_t0, rsp_op, rsp_err, rsp_stat, rsp_data);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 128'(rsp_valid), 128'd1);
      chk({nm, "_hold_rsp"}, {rsp_data[119:0], rsp_stat}, {exp_data[119:0], exp_stat});
      chk({nm, "_hold_operr"}, 128'({rsp_op, rsp_err}), 128'({exp_op, exp_err}));
      chk({nm, "_hold_cmd_ready"}, 128'(cmd_ready), 128'd0);
    end
    if (ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, "_ready_after"}, 128'(cmd_ready), 128'd1);
      chk({nm, "_valid_after"}, 128'(rsp_valid), 128'd0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_strobes"}, 128'({wr_out, rd_out, addr_out, data_out}), 128'd0);
    chk({nm, "_handshake"}, 128'({cmd_ready, rsp_valid}), 128'd0);
    chk({nm, "_rsp"}, 128'({rsp_op, rsp_err, rsp_stat}), 128'd0);
    chk({nm, "_data"}, rsp_data, 128'd0);
  endtask

  initial begin
    int g;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; rsp_ready = 1'b0;
    cur_ca = 8'h00; ok_poll = 1; poll_seen = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("idle_ready", 128'(cmd_ready), 128'd1);

    // Op 0: time read, ok on first poll
    regs[32'h10] = 32'h0000_1234; regs[32'h14] = 32'h89AB_CDEF;
    regs[32'h18] = 32'h2AAA_AAAA; regs[32'h1C] = 32'h0000_005B;
    ok_poll = 1;
    issue(2'd0);
    wait_rsp(0, 1'b1, "op0");
    chk("op0_lat_lit", 128'(got_rsp_cyc - last_t0), 128'd14);
    chk("op0_sec_lit", 128'(got_data[85:38]), 128'h1234_89AB_CDEF);
    chk("op0_ns_lit", 128'(got_data[37:0]), 128'({30'h2AAA_AAAA, 8'h5B}));
    chk("op0_polls_lit", 128'(poll_seen), 128'd1);

    // Op 1: RX pop, ok on third poll
    regs[32'h44] = 32'hFF00_0007; regs[32'h50] = 32'h1111_1111; regs[32'h54] = 32'h2222_2222;
    regs[32'h58] = 32'h3333_3333; regs[32'h5C] = 32'h4444_4444;
    ok_poll = 3;
    issue(2'd1);
    wait_rsp(0, 1'b1, "op1");
    chk("op1_lat_lit", 128'(got_rsp_cyc - last_t0), 128'd19);
    chk("op1_stat_lit", 128'(got_stat), 128'h07);
    chk("op1_data_lit", got_data, 128'h11111111_22222222_33333333_44444444);
    chk("op1_polls_lit", 128'(poll_seen), 128'd3);

    // Op 2: TX pop, ok never set -> timeout after POLL_MAX polls
    regs[32'h64] = 32'h0000_00A5; regs[32'h70] = 32'h5555_5555;
    ok_poll = 0;
    issue(2'd2);
    wait_rsp(0, 1'b1, "op2_tmo");
    chk("op2_polls_lit", 128'(poll_seen), 128'd255);
    chk("op2_data_lit", got_data, 128'd0);

    // Illegal op with response stalled for 5 cycles
    issue(2'd3);
    wait_rsp(5, 1'b1, "op3");
    chk("op3_lat_lit", 128'(got_rsp_cyc - last_t0), 128'd1);

    // Reset at cycle 8 of an op 1 aborts it; next op 0 runs cleanly
    ok_poll = 3;
    issue(2'd1);
    g = 0;
    while (cyc != last_t0 + 8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rst_reach_cyc8", 128'(cyc - last_t0), 128'd8);
    rst = 1'b1;
    exp_kind.delete(); exp_a.delete(); exp_d.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    ok_poll = 1;
    issue(2'd0);
    wait_rsp(0, 1'b1, "post_rst");

    // Back-to-back with rsp_ready tied high
    rsp_ready = 1'b1;
    ok_poll = 1;
    issue(2'd0);
    wait_rsp(0, 1'b0, "b2b_a");
    g = got_rsp_cyc;
    issue(2'd1);
    chk("b2b_gap", 128'(last_t0 - g), 128'd1);
    wait_rsp(0, 1'b1, "b2b_b");
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ptp_regs_seq.md
Name: ptp_regs_seq

Overview:
- Bus-master sequencer for the PTP register file (RTC + RX/TX timestamp queue map, 8-bit byte address, 32-bit data, 1-cycle registered read data).
- Turns single-word commands into the full register choreography: edge-toggle a control bit, wait for the status bit to settle, poll the ok flag, then burst-read the result words.
- Sits between a local controller (servo/DMA engine) and the register file's generic bus port. Returns one packed response per command.

Parameters:
- SETTLE_CYC, 4, idle bus cycles after the trigger write before the first poll; legal range 2..15.
- POLL_MAX, 255, maximum poll reads before timeout; legal range 1..255.

Ports:
- clk  in  1  system clock; same clock as the register file bus.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  command: 0 = RTC time read, 1 = RX queue pop, 2 = TX queue pop, 3 = illegal.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response accept.
- rsp_op  out  2  echo of the command's cmd_op.
- rsp_err  out  1  set for timeout or illegal op.
- rsp_stat  out  8  queue status word [7:0]; 0 for time reads.
- rsp_data  out  128  result payload.
- wr_out  out  1  register write strobe.
- rd_out  out  1  register read strobe.
- addr_out  out  8  register byte address.
- data_out  out  32  write data.
- data_in  in  32  read data; valid the cycle after rd_out.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-command aborts it with no response. A control bit left set by the aborted command is cleared by the CLR write of the next command.
- Strobes: at most one of wr_out/rd_out per cycle. addr_out/data_out are 0 when no strobe is active.
- Command/response: a command is accepted on cmd_valid && cmd_ready in IDLE; call that cycle 0. cmd_op is sampled in cycle 0; op, err, stat and data are registered. cmd_op = 3 → RESP next cycle with rsp_err = 1, data = 0, and no bus activity.
- Control address CA and bit 0 as trigger: CA = 0x00 for op 0, 0x40 for op 1, 0x60 for op 2. All other bits in those writes are 0.
- States: IDLE → CLR → SET → SETTLE → POLL_RD → POLL_CHK → FETCH → RESP → IDLE.
- CLR (cycle 1): write CA = 0x0.
- SET (cycle 2): write CA = 0x1.
- SETTLE: SETTLE_CYC cycles with no strobes.
- POLL_RD: read CA, increment poll count.
- POLL_CHK: sample data_in[0].
  - 1 → FETCH.
  - 0 and count < POLL_MAX → POLL_RD, so polls are spaced 2 cycles apart.
  - 0 and count == POLL_MAX → RESP with rsp_err = 1, data = 0, stat = 0.
- FETCH: back-to-back reads, one per cycle. Each word is captured the cycle after its read.
  - op 0: reads 0x10, 0x14, 0x18, 0x1C (N = 4).
  - op 1: reads 0x44, 0x50, 0x54, 0x58, 0x5C (N = 5).
  - op 2: reads 0x64, 0x70, 0x74, 0x78, 0x7C (N = 5).
- FETCH → RESP one cycle after the last capture.
- Packing, op 0:
  - rsp_data[85:38] = {w10[15:0], w14}, the 48-bit seconds.
  - rsp_data[37:0] = {w18[29:0], w1C[7:0]}, the 38-bit ns.fraction.
  - rsp_data[127:86] = 0.
- Packing, ops 1/2:
  - rsp_stat = first word [7:0].
  - rsp_data = {w50, w54, w58, w5C}, or {w70, w74, w78, w7C} for op 2; first-read word is the MSB.
- RESP: rsp_valid high. On rsp_ready → IDLE, with cmd_ready high the following cycle. rsp_* stay stable while rsp_valid && !rsp_ready.
- Latency with first-poll success, S = SETTLE_CYC:
  - first poll read at cycle 3+S;
  - fetch reads at cycles 5+S .. 4+S+N;
  - rsp_valid at cycle 6+S+N.
  - Defaults: op 0 → cycle 14, ops 1/2 → cycle 15.
  - Each extra failed poll adds 2 cycles.
- Poll count is 8 bits and resets at each new command; no wrap is possible because POLL_MAX ≤ 255.

Test Plan:
- Op 0 with slave model returning ok on the first poll, and 0x10 = 0x1234, 0x14 = 0x89ABCDEF, 0x18 = 0x2AAAAAAA, 0x1C = 0x5B → writes 0x00 = 0 at cycle 1 and 0x00 = 1 at cycle 2; poll at cycle 7; rsp_valid at cycle 14; rsp_data[85:38] = 0x123489ABCDEF; rsp_data[37:0] = {30'h2AAAAAAA, 8'h5B}; rsp_err = 0.
- Op 1 with ok on the third poll, 0x44 = 0xFF000007, 0x50..0x5C = 0x11111111..0x44444444 → polls at cycles 7/9/11; rsp_valid at cycle 19; rsp_stat = 0x07; rsp_data = 0x11111111222222223333333344444444.
- Op 2 with ok never set and POLL_MAX = 255 → exactly 255 reads of 0x60, then rsp_valid with rsp_err = 1, data = 0, rsp_op = 2.
- cmd_op = 3 → no strobes; rsp_valid at cycle 1 with rsp_err = 1. Hold rsp_ready = 0 for 5 cycles → outputs stable and cmd_ready = 0 throughout.
- Assert rst at cycle 8 of an op 1 → all outputs 0 at the next cycle. A new op 0 then starts with a write of 0x00 = 0 and completes normally.
- Back-to-back commands with rsp_ready tied high → second command accepted 1 cycle after the first response, with no overlapping strobes.
